// File: rtl/uart_rgb_cmd_pwm_if.sv
// Byte stream from the UART receiver, plus the RGB/status outputs of the PWM command block.
interface uart_rgb_cmd_pwm_if;
    logic [7:0] rxbyte;
    logic       received;
    logic [2:0] rgb;
    logic       cmd_ok;
    logic       cmd_err;

    modport master (output rxbyte, output received, input rgb, input cmd_ok, input cmd_err);
    modport slave  (input rxbyte, input received, output rgb, output cmd_ok, output cmd_err);
endinterface

// File: rtl/uart_rgb_cmd_pwm.sv
// ASCII command parser (<ch><H><L>, X) that sets per-channel brightness, driving
// glitch-free RGB PWM whose duty updates only at period boundaries.
module uart_rgb_cmd_pwm #(
    parameter int             PWM_BITS       = 8,
    parameter int             TIMEOUT_CYCLES = 12_000_000,
    parameter logic [7:0]     RST_DUTY_R     = 8'hFF,
    parameter logic [7:0]     RST_DUTY_G     = 8'h00,
    parameter logic [7:0]     RST_DUTY_B     = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rgb_cmd_pwm_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_ch;
    logic [3:0]          r_hi;
    logic [TW-1:0]       r_to_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [2:0]          r_rgb;
    logic                r_cmd_ok;
    logic                r_cmd_err;

    logic                w_ok_next;
    logic                w_err_next;
    logic                w_wr_en;
    logic                w_clr_all;
    logic                w_latch_ch;
    logic                w_latch_hi;
    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic                w_is_ch;
    logic [1:0]          w_ch_idx;

    // Decode the incoming byte as a hex digit and as a channel letter.
    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'd0;
        w_is_ch  = 1'b0;
        w_ch_idx = 2'd0;
        if (bus.rxbyte >= 8'h30 && bus.rxbyte <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = bus.rxbyte[3:0];
        end else if ((bus.rxbyte >= 8'h41 && bus.rxbyte <= 8'h46) ||
                     (bus.rxbyte >= 8'h61 && bus.rxbyte <= 8'h66)) begin
            w_is_hex = 1'b1;
            w_nib    = bus.rxbyte[3:0] + 4'd9;
        end
        case (bus.rxbyte)
            8'h52, 8'h72: begin w_is_ch = 1'b1; w_ch_idx = 2'd0; end
            8'h47, 8'h67: begin w_is_ch = 1'b1; w_ch_idx = 2'd1; end
            8'h42, 8'h62: begin w_is_ch = 1'b1; w_ch_idx = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_ok_next    = 1'b0;
        w_err_next   = 1'b0;
        w_wr_en      = 1'b0;
        w_clr_all    = 1'b0;
        w_latch_ch   = 1'b0;
        w_latch_hi   = 1'b0;
        if (bus.received) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_ch) begin
                        w_latch_ch   = 1'b1;
                        w_state_next = S_HI;
                    end else if (bus.rxbyte == 8'h58 || bus.rxbyte == 8'h78) begin
                        w_clr_all = 1'b1;
                        w_ok_next = 1'b1;
                    end else if (bus.rxbyte != 8'h0D && bus.rxbyte != 8'h0A) begin
                        w_err_next = 1'b1;
                    end
                end
                S_HI: begin
                    if (w_is_hex) begin
                        w_latch_hi   = 1'b1;
                        w_state_next = S_LO;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    if (w_is_hex) begin
                        w_wr_en   = 1'b1;
                        w_ok_next = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            endcase
        end else if (r_state != S_IDLE && r_to_cnt == TO_LAST) begin
            w_state_next = S_IDLE;
            w_err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ch      <= 2'd0;
            r_hi      <= 4'd0;
            r_to_cnt  <= '0;
            r_pwm_cnt <= '0;
            r_cmd_ok  <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cmd_ok  <= w_ok_next;
            r_cmd_err <= w_err_next;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_latch_ch) r_ch <= w_ch_idx;
            if (w_latch_hi) r_hi <= w_nib;
            if (bus.received || r_state == S_IDLE) r_to_cnt <= '0;
            else                                   r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            localparam logic [7:0] RST_V = (gi == 0) ? RST_DUTY_R :
                                           (gi == 1) ? RST_DUTY_G : RST_DUTY_B;
            logic [PWM_BITS-1:0] r_shadow;
            logic [PWM_BITS-1:0] r_active;

            // Active duty reloads only at the last count, so every period is whole.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_shadow  <= PWM_BITS'(RST_V);
                    r_active  <= PWM_BITS'(RST_V);
                    r_rgb[gi] <= 1'b0;
                end else begin
                    if (w_clr_all)
                        r_shadow <= '0;
                    else if (w_wr_en && r_ch == 2'(gi))
                        r_shadow <= PWM_BITS'({r_hi, w_nib});
                    if (r_pwm_cnt == {PWM_BITS{1'b1}})
                        r_active <= r_shadow;
                    r_rgb[gi] <= (r_pwm_cnt < r_active);
                end
            end
        end
    endgenerate

    assign bus.rgb     = r_rgb;
    assign bus.cmd_ok  = r_cmd_ok;
    assign bus.cmd_err = r_cmd_err;
endmodule

// File: tb/tb_uart_rgb_cmd_pwm.sv
// Directed bench: table of command vectors with expected pulses and duty counts,
// then hand sequences for timeout, expiry-cycle byte and mid-command reset.
module tb_uart_rgb_cmd_pwm;
    localparam int T = 40;

    logic clk = 1'b0;
    logic rst_n;
    uart_rgb_cmd_pwm_if bus ();

    uart_rgb_cmd_pwm #(.PWM_BITS(8), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int             n;
        logic [7:0]     by0, by1, by2;
        logic           ok, err;
        int             dr, dg, db;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rxbyte   = b;
        bus.received = 1'b1;
        @(posedge clk); #1;
        bus.received = 1'b0;
    endtask

    task automatic measure(output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (300) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            c0 += int'(bus.rgb[0]);
            c1 += int'(bus.rgb[1]);
            c2 += int'(bus.rgb[2]);
        end
    endtask

    task automatic set_vec(input int idx, input int n, input logic [7:0] b0, b1, b2,
                           input logic ok, input logic err, input int r, g, b);
        vecs[idx].n   = n;
        vecs[idx].by0 = b0; vecs[idx].by1 = b1; vecs[idx].by2 = b2;
        vecs[idx].ok  = ok; vecs[idx].err = err;
        vecs[idx].dr  = r;  vecs[idx].dg  = g;  vecs[idx].db = b;
    endtask

    initial begin
        int c0, c1, c2, hits, at;
        logic [7:0] bb;

        set_vec(0, 3, "G", "8", "0", 1, 0, 255, 128, 0);
        set_vec(1, 3, "b", "f", "F", 1, 0, 255, 128, 255);
        set_vec(2, 1, "x", 0, 0,     1, 0, 0, 0, 0);
        set_vec(3, 3, "r", "A", "5", 1, 0, 165, 0, 0);
        set_vec(4, 2, "R", "Z", 0,   0, 1, 165, 0, 0);
        set_vec(5, 1, "Q", 0, 0,     0, 1, 165, 0, 0);
        set_vec(6, 1, 8'h0D, 0, 0,   0, 0, 165, 0, 0);
        set_vec(7, 1, 8'h0A, 0, 0,   0, 0, 165, 0, 0);
        set_vec(8, 3, "g", "0", "1", 1, 0, 165, 1, 0);
        set_vec(9, 3, "B", "7", "g", 0, 1, 165, 1, 0);

        rst_n = 1'b0;
        bus.rxbyte = 8'h00;
        bus.received = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset rgb", int'(bus.rgb), 0);
        check("reset cmd_ok", int'(bus.cmd_ok), 0);
        check("reset cmd_err", int'(bus.cmd_err), 0);
        rst_n = 1'b1;

        repeat (256) @(posedge clk);
        measure(c0, c1, c2);
        check("reset duty red", c0, 255);
        check("reset duty green", c1, 0);
        check("reset duty blue", c2, 0);

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                bb = (k == 0) ? vecs[v].by0 : (k == 1) ? vecs[v].by1 : vecs[v].by2;
                send_byte(bb);
                if (k == vecs[v].n - 1) begin
                    check($sformatf("v%0d ok pulse", v), int'(bus.cmd_ok), int'(vecs[v].ok));
                    check($sformatf("v%0d err pulse", v), int'(bus.cmd_err), int'(vecs[v].err));
                    @(posedge clk); #1;
                    check($sformatf("v%0d pulse ends", v), int'({bus.cmd_ok, bus.cmd_err}), 0);
                end else begin
                    check($sformatf("v%0d byte%0d no pulse", v, k),
                          int'({bus.cmd_ok, bus.cmd_err}), 0);
                end
            end
            measure(c0, c1, c2);
            check($sformatf("v%0d red", v), c0, vecs[v].dr);
            check($sformatf("v%0d green", v), c1, vecs[v].dg);
            check($sformatf("v%0d blue", v), c2, vecs[v].db);
        end

        // Abandoned command: exactly one error, T cycles after the last byte.
        send_byte("R");
        send_byte("4");
        hits = 0; at = -1;
        for (int n = 1; n <= T + 5; n++) begin
            @(posedge clk); #1;
            if (bus.cmd_err) begin
                hits++;
                if (at < 0) at = n;
            end
            if (bus.cmd_ok) hits += 100;
        end
        check("timeout err count", hits, 1);
        check("timeout err cycle", at, T);
        send_byte("R");
        send_byte("4");
        send_byte("0");
        check("post-timeout ok", int'(bus.cmd_ok), 1);
        measure(c0, c1, c2);
        check("post-timeout red", c0, 64);

        // Byte arriving on the expiry cycle is processed and suppresses the timeout.
        send_byte("G");
        send_byte("4");
        repeat (T - 2) @(posedge clk);
        send_byte("0");
        check("expiry ok", int'(bus.cmd_ok), 1);
        check("expiry no err", int'(bus.cmd_err), 0);
        hits = 0;
        for (int n = 0; n < T + 5; n++) begin
            @(posedge clk); #1;
            hits += int'(bus.cmd_err);
        end
        check("expiry no late err", hits, 0);
        measure(c0, c1, c2);
        check("expiry green", c1, 64);

        // Reset in the middle of a command.
        send_byte("B");
        send_byte("1");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset rgb", int'(bus.rgb), 0);
        check("midreset pulses", int'({bus.cmd_ok, bus.cmd_err}), 0);
        rst_n = 1'b1;
        send_byte("1");
        check("midreset idle err", int'(bus.cmd_err), 1);
        check("midreset idle ok", int'(bus.cmd_ok), 0);
        measure(c0, c1, c2);
        check("midreset red", c0, 255);
        check("midreset green", c1, 0);
        check("midreset blue", c2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
